// File: rtl/hdmi_line_feeder.sv
// Pixel supply for the HDMI output path: fetches frame lines from memory in CHUNK-word
// bursts into a first-word-fall-through FIFO and pops one pixel per active-video cycle.
module hdmi_line_feeder #(
  parameter int unsigned CHUNK = 32,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [10:0]   hres,
  input  logic [9:0]    vres,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] stride,
  input  logic          read_go,
  input  logic          read_next_line,
  input  logic          read_done,
  input  logic          ve,
  output logic [23:0]   color,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic          mem_valid,
  input  logic [31:0]   mem_data,
  output logic          underrun,
  output logic          line_err
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, REQ, BURST, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] stride_q, stride_d;
  logic [AW-1:0] line_addr_q, line_addr_d;
  logic [AW-1:0] chunk_addr_q, chunk_addr_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [10:0]   pix_q, pix_d;
  logic [10:0]   popped_q, popped_d;
  logic [9:0]    lines_q, lines_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] count_q;
  logic [PW-1:0] wptr_q, rptr_q;
  logic [23:0]   fifo_q [DEPTH];
  logic          mem_req_q, mem_req_d;
  logic          go_pend_q, go_pend_d;
  logic          underrun_q, underrun_d;
  logic          line_err_q, line_err_d;
  logic          wr_en, pop, flush, frame_start, go, abort;
  logic [CW-1:0] free;
  logic          unused_hi;

  assign go        = read_go & start;
  assign abort     = read_done | ~start | read_go;
  assign pop       = ve & (count_q != '0);
  assign free      = CW'(DEPTH) - count_q - inflight_q;
  assign unused_hi = ^mem_data[31:24];

  always_comb begin
    state_d      = state_q;
    stride_d     = stride_q;
    line_addr_d  = line_addr_q;
    chunk_addr_d = chunk_addr_q;
    mem_addr_d   = mem_addr_q;
    pix_d        = pix_q;
    popped_d     = popped_q;
    lines_d      = lines_q;
    inflight_d   = inflight_q;
    mem_req_d    = mem_req_q;
    go_pend_d    = go_pend_q;
    underrun_d   = underrun_q;
    line_err_d   = line_err_q;
    wr_en        = 1'b0;
    flush        = 1'b0;
    frame_start  = 1'b0;

    if (ve && count_q == '0) underrun_d = 1'b1;
    if (read_next_line) begin
      if (popped_q != hres) line_err_d = 1'b1;
      popped_d = {10'd0, pop};
    end else if (pop) begin
      popped_d = popped_q + 11'd1;
    end

    case (state_q)
      IDLE: if (go) frame_start = 1'b1;
      REQ: begin
        if (abort) begin
          mem_req_d = 1'b0;
          // An ack landing with the abort still owes CHUNK beats; soak them up in DRAIN.
          if (mem_req_q && mem_ack) begin
            inflight_d = CW'(CHUNK);
            go_pend_d  = go;
            state_d    = DRAIN;
          end else begin
            flush = 1'b1;
            if (go) frame_start = 1'b1;
            else    state_d     = IDLE;
          end
        end else if (mem_req_q) begin
          if (mem_ack) begin
            mem_req_d  = 1'b0;
            inflight_d = CW'(CHUNK);
            state_d    = BURST;
          end
        end else if (lines_q != vres && free >= CW'(CHUNK)) begin
          mem_req_d  = 1'b1;
          mem_addr_d = chunk_addr_q;
        end
      end
      BURST: begin
        if (abort) begin
          go_pend_d = go;
          state_d   = DRAIN;
          if (mem_valid) inflight_d = inflight_q - CW'(1);
        end else if (mem_valid) begin
          wr_en      = 1'b1;
          inflight_d = inflight_q - CW'(1);
          if (inflight_q == CW'(1)) begin
            state_d = REQ;
            if (pix_q + 11'(CHUNK) == hres) begin
              pix_d        = '0;
              line_addr_d  = line_addr_q + stride_q;
              chunk_addr_d = line_addr_q + stride_q;
              lines_d      = lines_q + 10'd1;
            end else begin
              pix_d        = pix_q + 11'(CHUNK);
              chunk_addr_d = chunk_addr_q + AW'(CHUNK * 4);
            end
          end
        end
      end
      DRAIN: begin
        go_pend_d = (go_pend_q | read_go) & start;
        if (inflight_q == '0 || (inflight_q == CW'(1) && mem_valid)) begin
          inflight_d = '0;
          flush      = 1'b1;
          if (go_pend_d) frame_start = 1'b1;
          else           state_d     = IDLE;
        end else if (mem_valid) begin
          inflight_d = inflight_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (frame_start) begin
      stride_d     = stride;
      line_addr_d  = base_addr;
      chunk_addr_d = base_addr;
      pix_d        = '0;
      lines_d      = '0;
      popped_d     = '0;
      inflight_d   = '0;
      mem_req_d    = 1'b0;
      go_pend_d    = 1'b0;
      underrun_d   = 1'b0;
      line_err_d   = 1'b0;
      flush        = 1'b1;
      state_d      = REQ;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      stride_q     <= '0;
      line_addr_q  <= '0;
      chunk_addr_q <= '0;
      mem_addr_q   <= '0;
      pix_q        <= '0;
      popped_q     <= '0;
      lines_q      <= '0;
      inflight_q   <= '0;
      mem_req_q    <= 1'b0;
      go_pend_q    <= 1'b0;
      underrun_q   <= 1'b0;
      line_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      stride_q     <= stride_d;
      line_addr_q  <= line_addr_d;
      chunk_addr_q <= chunk_addr_d;
      mem_addr_q   <= mem_addr_d;
      pix_q        <= pix_d;
      popped_q     <= popped_d;
      lines_q      <= lines_d;
      inflight_q   <= inflight_d;
      mem_req_q    <= mem_req_d;
      go_pend_q    <= go_pend_d;
      underrun_q   <= underrun_d;
      line_err_q   <= line_err_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + PW'(1);
      if (pop)   rptr_q <= rptr_q + PW'(1);
      count_q <= count_q + CW'(wr_en) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) fifo_q[wptr_q] <= mem_data[23:0];
  end

  assign color    = (count_q != '0) ? fifo_q[rptr_q] : '0;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign underrun = underrun_q;
  assign line_err = line_err_q;
endmodule
